// File: rtl/vend_session_ctrl.sv
// Vending session controller: accumulates coin credit, validates selections
// against price and stock, runs the dispense req/ack handshake and pays change
// back one unit coin at a time. All outputs come straight from registers.
module vend_session_ctrl #(
    parameter int unsigned PRICE0     = 3,
    parameter int unsigned PRICE1     = 5,
    parameter int unsigned PRICE2     = 7,
    parameter int unsigned PRICE3     = 10,
    parameter int unsigned CREDIT_MAX = 31,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic [3:0] stock_empty,
    input  logic       dispense_ack,
    input  logic       change_ack,
    output logic       dispense_req,
    output logic [1:0] dispense_item,
    output logic       change_req,
    output logic       coin_reject,
    output logic       sel_err,
    output logic [7:0] credit,
    output logic       busy
);

    localparam int unsigned      TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TMO_ONE   = TW'(32'd1);
    localparam logic [8:0]       CMAX9     = 9'(CREDIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    // Price lookup for the selected item index.
    function automatic logic [7:0] price_of(input logic [1:0] idx);
        logic [7:0] p;
        case (idx)
            2'd0:    p = 8'(PRICE0);
            2'd1:    p = 8'(PRICE1);
            2'd2:    p = 8'(PRICE2);
            2'd3:    p = 8'(PRICE3);
            default: p = 8'(PRICE3);
        endcase
        return p;
    endfunction

    state_t          state_r, state_s;
    logic [7:0]      credit_r, credit_s;
    logic [TW-1:0]   tmo_r, tmo_s;
    logic            dreq_r, dreq_s;
    logic [1:0]      ditem_r, ditem_s;
    logic            creq_r, creq_s;
    logic            rej_r, rej_s;
    logic            serr_r, serr_s;
    logic            busy_r, busy_s;

    logic [8:0]      sum_s;
    logic            coin_ok_s;
    logic            coin_any_s;
    logic [7:0]      price_s;
    logic            sel_ok_s;

    assign sum_s      = {1'b0, credit_r} + {7'd0, in};
    assign coin_any_s = (in != 2'd0);
    assign coin_ok_s  = ((in == 2'd1) || (in == 2'd2)) && (sum_s <= CMAX9);
    assign price_s    = price_of(sel);
    assign sel_ok_s   = !stock_empty[sel] && (credit_r >= price_s);

    // Next-state, next-credit and next-output decode for the session FSM.
    always_comb begin
        state_s  = state_r;
        credit_s = credit_r;
        tmo_s    = tmo_r;
        ditem_s  = ditem_r;
        rej_s    = 1'b0;
        serr_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                tmo_s = '0;
                if ((in == 2'd1) || (in == 2'd2)) begin
                    credit_s = {6'd0, in};
                    state_s  = S_CREDIT;
                end else if (in == 2'd3) begin
                    rej_s = 1'b1;
                end else begin
                    rej_s = 1'b0;
                end
                if (sel_valid) begin
                    serr_s = 1'b1;
                end else begin
                    serr_s = 1'b0;
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    // Refund wins over everything; a coin alongside is handed back.
                    rej_s   = coin_any_s;
                    tmo_s   = '0;
                    state_s = S_CHANGE;
                end else if (sel_valid) begin
                    rej_s = coin_any_s;
                    tmo_s = '0;
                    if (sel_ok_s) begin
                        credit_s = credit_r - price_s;
                        ditem_s  = sel;
                        state_s  = S_DISPENSE;
                    end else begin
                        serr_s = 1'b1;
                    end
                end else if (coin_ok_s) begin
                    credit_s = sum_s[7:0];
                    tmo_s    = '0;
                end else begin
                    // Idle cycle (a rejected coin counts as idle too).
                    rej_s = coin_any_s;
                    if (tmo_r == TMO_LAST) begin
                        tmo_s   = '0;
                        state_s = S_CHANGE;
                    end else begin
                        tmo_s = tmo_r + TMO_ONE;
                    end
                end
            end
            S_DISPENSE: begin
                rej_s = coin_any_s;
                if (dispense_ack) begin
                    if (credit_r != 8'd0) begin
                        state_s = S_CHANGE;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_DISPENSE;
                end
            end
            S_CHANGE: begin
                rej_s = coin_any_s;
                if (credit_r == 8'd0) begin
                    // Nothing owed: never hold the hopper request with zero credit.
                    state_s = S_IDLE;
                end else if (change_ack) begin
                    credit_s = credit_r - 8'd1;
                    if (credit_r == 8'd1) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_CHANGE;
                    end
                end else begin
                    state_s = S_CHANGE;
                end
            end
            default: begin
                state_s  = S_IDLE;
                credit_s = 8'd0;
                tmo_s    = '0;
            end
        endcase
        dreq_s = (state_s == S_DISPENSE);
        creq_s = (state_s == S_CHANGE);
        busy_s = dreq_s | creq_s;
    end

    // State, credit, timeout counter and output registers; reset aborts any session.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_IDLE;
            credit_r <= 8'd0;
            tmo_r    <= '0;
            dreq_r   <= 1'b0;
            ditem_r  <= 2'd0;
            creq_r   <= 1'b0;
            rej_r    <= 1'b0;
            serr_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            credit_r <= credit_s;
            tmo_r    <= tmo_s;
            dreq_r   <= dreq_s;
            ditem_r  <= ditem_s;
            creq_r   <= creq_s;
            rej_r    <= rej_s;
            serr_r   <= serr_s;
            busy_r   <= busy_s;
        end
    end

    assign dispense_req  = dreq_r;
    assign dispense_item = ditem_r;
    assign change_req    = creq_r;
    assign coin_reject   = rej_r;
    assign sel_err       = serr_r;
    assign credit        = credit_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Scoreboard bench for vend_session_ctrl: a behavioural session model predicts
// the outputs after every clock edge, a monitor pops and compares them.
module tb_vend_session_ctrl;

    localparam int TMO  = 12;
    localparam int CMAX = 31;
    localparam int M_IDLE = 0, M_CREDIT = 1, M_DISP = 2, M_CHANGE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic [3:0] stock_empty;
    logic       dispense_ack;
    logic       change_ack;
    logic       dispense_req;
    logic [1:0] dispense_item;
    logic       change_req;
    logic       coin_reject;
    logic       sel_err;
    logic [7:0] credit;
    logic       busy;

    vend_session_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in(in), .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .stock_empty(stock_empty), .dispense_ack(dispense_ack),
        .change_ack(change_ack), .dispense_req(dispense_req),
        .dispense_item(dispense_item), .change_req(change_req),
        .coin_reject(coin_reject), .sel_err(sel_err), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       dreq;
        bit [1:0] ditem;
        bit       creq;
        bit       rej;
        bit       serr;
        int       cred;
        bit       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   have_pend = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // behavioural session model
    int m_mode = M_IDLE, m_credit = 0, m_idle = 0, m_item = 0;
    int price[4] = '{3, 5, 7, 10};

    task automatic model_step(input int c, input bit sv, input int s, input bit can,
                              input bit [3:0] se, input bit da, input bit ca);
        bit rej = 1'b0, serr = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (c == 1 || c == 2) begin
                    m_credit = c; m_idle = 0; m_mode = M_CREDIT;
                end else if (c == 3) rej = 1'b1;
                if (sv) serr = 1'b1;
            end
            M_CREDIT: begin
                if (can) begin
                    rej = (c != 0); m_mode = M_CHANGE; m_idle = 0;
                end else if (sv) begin
                    rej = (c != 0); m_idle = 0;
                    if (se[s] || m_credit < price[s]) serr = 1'b1;
                    else begin
                        m_credit -= price[s]; m_item = s; m_mode = M_DISP;
                    end
                end else if ((c == 1 || c == 2) && m_credit + c <= CMAX) begin
                    m_credit += c; m_idle = 0;
                end else begin
                    rej = (c != 0); m_idle++;
                    if (m_idle >= TMO) begin m_mode = M_CHANGE; m_idle = 0; end
                end
            end
            M_DISP: begin
                rej = (c != 0);
                if (da) m_mode = (m_credit > 0) ? M_CHANGE : M_IDLE;
            end
            default: begin
                rej = (c != 0);
                if (ca) begin
                    m_credit--;
                    if (m_credit == 0) m_mode = M_IDLE;
                end
            end
        endcase
        pend.dreq  = (m_mode == M_DISP);
        pend.ditem = 2'(m_item);
        pend.creq  = (m_mode == M_CHANGE);
        pend.rej   = rej;
        pend.serr  = serr;
        pend.cred  = m_credit;
        pend.busy  = (m_mode == M_DISP) || (m_mode == M_CHANGE);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_item = 0;
    endtask

    // drive one cycle of stimulus and queue the expectation for the next edge
    task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s,
                        input logic can, input logic [3:0] se, input logic da, input logic ca);
        @(posedge clk); #1;
        if (have_pend) exp_q.push_back(pend);
        in = c; sel_valid = sv; sel = s; cancel = can;
        stock_empty = se; dispense_ack = da; change_ack = ca;
        model_step(int'(c), sv, int'(s), can, se, da, ca);
        have_pend = 1'b1;
    endtask

    task automatic flush();
        @(posedge clk); #1;
        if (have_pend) exp_q.push_back(pend);
        have_pend = 1'b0;
        in = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        stock_empty = 4'd0; dispense_ack = 1'b0; change_ack = 1'b0;
    endtask

    task automatic coin(input logic [1:0] v);
        step(v, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask
    task automatic nop();
        step(2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask
    task automatic pick(input logic [1:0] s, input logic [3:0] se);
        step(2'd0, 1'b1, s, 1'b0, se, 1'b0, 1'b0);
    endtask
    task automatic dack();
        step(2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask
    task automatic cack();
        step(2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask
    task automatic refund_all();
        for (int i = 0; i < 40 && m_mode != M_IDLE; i++) cack();
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (dispense_req !== e.dreq || change_req !== e.creq || coin_reject !== e.rej ||
                sel_err !== e.serr || credit !== 8'(e.cred) || busy !== e.busy ||
                (e.dreq && dispense_item !== e.ditem)) begin
                bad++;
                $display("FAIL outputs @%0d: got dreq=%b item=%0d creq=%b rej=%b serr=%b credit=%0d busy=%b expected dreq=%b item=%0d creq=%b rej=%b serr=%b credit=%0d busy=%b",
                         cyc, dispense_req, dispense_item, change_req, coin_reject, sel_err, credit, busy,
                         e.dreq, e.ditem, e.creq, e.rej, e.serr, e.cred, e.busy);
            end
        end
    end

    initial begin
        // reset with stimulus active
        rst = 1'b0;
        in = 2'd2; sel_valid = 1'b1; sel = 2'd1; cancel = 1'b1;
        stock_empty = 4'd0; dispense_ack = 1'b1; change_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dreq", int'(dispense_req), 0);
        chk("rst_creq", int'(change_req), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_pulses", int'({coin_reject, sel_err, busy, dispense_item}), 0);
        @(negedge clk);
        in = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        dispense_ack = 1'b0; change_ack = 1'b0;
        rst = 1'b1;
        model_reset();

        // exact price purchase: no change phase
        coin(2'd2); coin(2'd2); coin(2'd1);
        pick(2'd1, 4'd0);
        nop();
        dack();
        nop();

        // purchase with change, gap between hopper acks
        coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd1);
        pick(2'd0, 4'd0);
        dack();
        cack(); nop(); cack(); cack(); cack();
        nop();

        // refusals: too expensive, sold out, invalid coin, then cancel
        coin(2'd2); coin(2'd2);
        pick(2'd3, 4'd0);
        coin(2'd2); coin(2'd2);
        pick(2'd2, 4'b0100);
        coin(2'd3);
        step(2'd0, 1'b0, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        refund_all();

        // credit ceiling and same-cycle cancel + select + coin
        for (int i = 0; i < 15; i++) coin(2'd2);
        coin(2'd2);
        step(2'd1, 1'b1, 2'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        refund_all();

        // inactivity timeout refunds, coin during change rejected
        coin(2'd2); coin(2'd1);
        for (int i = 0; i < TMO; i++) nop();
        coin(2'd1);
        refund_all();
        nop();

        // reset in the middle of a dispense
        coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd2); coin(2'd1);
        pick(2'd0, 4'd0);
        nop(); nop();
        flush();
        @(negedge clk); #1;
        chk("pre_rst_dreq", int'(dispense_req), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_dreq", int'(dispense_req), 0);
        chk("mid_rst_creq", int'(change_req), 0);
        chk("mid_rst_credit", int'(credit), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("hold_rst_credit", int'(credit), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // randomized sessions
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] c;
            logic [3:0] se;
            if ($urandom_range(0, 149) == 0) begin
                for (int q = 0; q < TMO + 2; q++)
                    step(2'd0, 1'b0, 2'd0, 1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            c  = ($urandom_range(0, 99) < 55) ? 2'd0 : 2'($urandom_range(1, 3));
            se = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            step(c, 1'($urandom_range(0, 99) < 8), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 3), se,
                 1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 50));
        end
        flush();

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
